// File: rtl/alu_sched.sv
// rtl/alu_sched.sv - two-requester round-robin scheduler in front of a shared 64-bit ALU
//
// Purpose:
//   Shares one combinational 64-bit ALU between two independent requesters.
//   A request is granted round-robin, its operands are registered onto the
//   ALU inputs, the ALU result and NZVC flags are captured one cycle later,
//   and the captured response is returned on the owner's valid/ready channel.
//   Only one operation is in flight at a time.
//
// Optional feature:
//   ALU_SCHED_FLAGREG_EN - when defined, an architectural NZVC flag register
//   loads the ALU flags on the capture edge of operations accepted with
//   req_setflags=1. When undefined, flag_n/z/v/c are tied to 0 and
//   req_setflags is ignored.
//
// Ports:
//   clk, reset_n                 clock, asynchronous active-low reset
//   req_valid/req_ready [1:0]    per-requester request handshake
//   req_a/req_b [1:0][63:0]      per-requester operands
//   req_cntrl [1:0][2:0]         per-requester ALU op code
//   req_shiftdir/req_setflags    per-requester shift direction / flag update
//   rsp_valid/rsp_ready [1:0]    per-requester response handshake
//   rsp_result [63:0]            captured result (shared by both channels)
//   rsp_flags [3:0]              captured {negative, zero, overflow, carry_out}
//   alu_a/alu_b/alu_cntrl/alu_shiftdir   registered ALU operands
//   alu_result, alu_negative/zero/overflow/carry_out   ALU outputs
//   flag_n/flag_z/flag_v/flag_c  architectural flag register

module alu_sched (
    input  logic             clk,
    input  logic             reset_n,

    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0][63:0] req_a,
    input  logic [1:0][63:0] req_b,
    input  logic [1:0][2:0]  req_cntrl,
    input  logic [1:0]       req_shiftdir,
    input  logic [1:0]       req_setflags,

    output logic [1:0]       rsp_valid,
    input  logic [1:0]       rsp_ready,
    output logic [63:0]      rsp_result,
    output logic [3:0]       rsp_flags,

    output logic [63:0]      alu_a,
    output logic [63:0]      alu_b,
    output logic [2:0]       alu_cntrl,
    output logic             alu_shiftdir,
    input  logic [63:0]      alu_result,
    input  logic             alu_negative,
    input  logic             alu_zero,
    input  logic             alu_overflow,
    input  logic             alu_carry_out,

    output logic             flag_n,
    output logic             flag_z,
    output logic             flag_v,
    output logic             flag_c
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       owner;       // requester whose operation is in flight
    logic       last_grant;  // most recent winner; loses the next tie
    logic [1:0] grant_vec;   // one-hot arbitration result (independent of state)
    logic       grant_idx;
    logic       accept;
    logic       capture;
    logic       release_rsp;

    // Round-robin arbitration: a lone request wins outright, a tie goes to
    // the requester that did not win last time.
    always_comb begin
        grant_vec = 2'b00;
        case (req_valid)
            2'b01:   grant_vec = 2'b01;
            2'b10:   grant_vec = 2'b10;
            2'b11:   grant_vec = last_grant ? 2'b01 : 2'b10;
            default: grant_vec = 2'b00;
        endcase
    end

    assign grant_idx = grant_vec[1];

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)           state_next = EXEC;
            EXEC:                          state_next = RESP;
            RESP:    if (rsp_ready[owner]) state_next = IDLE;
            default:                       state_next = IDLE;
        endcase
    end

    // Output / control decode. req_ready is forced low while reset is
    // asserted so no handshake can appear during reset.
    always_comb begin
        req_ready   = 2'b00;
        capture     = 1'b0;
        release_rsp = 1'b0;
        case (state)
            IDLE:    req_ready   = reset_n ? grant_vec : 2'b00;
            EXEC:    capture     = 1'b1;
            RESP:    release_rsp = rsp_ready[owner];
            default: req_ready   = 2'b00;
        endcase
    end

    assign accept = |(req_valid & req_ready);

    // Operand registers: loaded only at accept, so request fields that change
    // while not ready never reach the ALU.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_a        <= 64'd0;
            alu_b        <= 64'd0;
            alu_cntrl    <= 3'b000;
            alu_shiftdir <= 1'b0;
            owner        <= 1'b0;
            last_grant   <= 1'b1;
        end else if (accept) begin
            alu_a        <= req_a[grant_idx];
            alu_b        <= req_b[grant_idx];
            alu_cntrl    <= req_cntrl[grant_idx];
            alu_shiftdir <= req_shiftdir[grant_idx];
            owner        <= grant_idx;
            last_grant   <= grant_idx;
        end
    end

    // Response registers: result and flags are captured once per operation
    // and then held until the next capture, independent of the handshake.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rsp_result <= 64'd0;
            rsp_flags  <= 4'b0000;
            rsp_valid  <= 2'b00;
        end else if (capture) begin
            rsp_result <= alu_result;
            rsp_flags  <= {alu_negative, alu_zero, alu_overflow, alu_carry_out};
            rsp_valid  <= owner ? 2'b10 : 2'b01;
        end else if (release_rsp) begin
            rsp_valid  <= 2'b00;
        end
    end

`ifdef ALU_SCHED_FLAGREG_EN
    logic setflags_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            setflags_q <= 1'b0;
        end else if (accept) begin
            setflags_q <= req_setflags[grant_idx];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            flag_n <= 1'b0;
            flag_z <= 1'b0;
            flag_v <= 1'b0;
            flag_c <= 1'b0;
        end else if (capture && setflags_q) begin
            flag_n <= alu_negative;
            flag_z <= alu_zero;
            flag_v <= alu_overflow;
            flag_c <= alu_carry_out;
        end
    end
`else
    // No flag register in this build; the per-requester setflags bits have
    // no effect.
    logic unused_setflags;
    assign unused_setflags = ^req_setflags;

    assign flag_n = 1'b0;
    assign flag_z = 1'b0;
    assign flag_v = 1'b0;
    assign flag_c = 1'b0;
`endif

endmodule

// File: tb/tb_alu_sched.sv
// tb/tb_alu_sched.sv - scoreboard testbench for alu_sched with a behavioural ALU model

module tb_alu_sched;

    logic             clk;
    logic             reset_n;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0][63:0] req_a;
    logic [1:0][63:0] req_b;
    logic [1:0][2:0]  req_cntrl;
    logic [1:0]       req_shiftdir;
    logic [1:0]       req_setflags;
    logic [1:0]       rsp_valid;
    logic [1:0]       rsp_ready;
    logic [63:0]      rsp_result;
    logic [3:0]       rsp_flags;
    logic [63:0]      alu_a;
    logic [63:0]      alu_b;
    logic [2:0]       alu_cntrl;
    logic             alu_shiftdir;
    logic [63:0]      alu_result;
    logic             alu_negative;
    logic             alu_zero;
    logic             alu_overflow;
    logic             alu_carry_out;
    logic             flag_n;
    logic             flag_z;
    logic             flag_v;
    logic             flag_c;

    alu_sched dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a         (req_a),
        .req_b         (req_b),
        .req_cntrl     (req_cntrl),
        .req_shiftdir  (req_shiftdir),
        .req_setflags  (req_setflags),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_result    (rsp_result),
        .rsp_flags     (rsp_flags),
        .alu_a         (alu_a),
        .alu_b         (alu_b),
        .alu_cntrl     (alu_cntrl),
        .alu_shiftdir  (alu_shiftdir),
        .alu_result    (alu_result),
        .alu_negative  (alu_negative),
        .alu_zero      (alu_zero),
        .alu_overflow  (alu_overflow),
        .alu_carry_out (alu_carry_out),
        .flag_n        (flag_n),
        .flag_z        (flag_z),
        .flag_v        (flag_v),
        .flag_c        (flag_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural ALU: returns {result, N, Z, V, C}.
    function automatic logic [67:0] alu_f(input logic [63:0] a, input logic [63:0] b,
                                          input logic [2:0] op, input logic dir);
        logic [64:0] s;
        logic [63:0] r;
        logic        c;
        logic        v;
        s = 65'd0;
        r = 64'd0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            3'b000: r = b;
            3'b001: r = dir ? (a >> b[5:0]) : (a << b[5:0]);
            3'b010: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[63:0];
                c = s[64];
                v = (a[63] == b[63]) && (r[63] != a[63]);
            end
            3'b011: begin
                r = a - b;
                c = (a >= b);
                v = (a[63] != b[63]) && (r[63] != a[63]);
            end
            3'b100: r = a & b;
            3'b101: r = a | b;
            3'b110: r = a ^ b;
            default: r = a * b;
        endcase
        return {r, r[63], (r == 64'd0), v, c};
    endfunction

    always_comb begin
        {alu_result, alu_negative, alu_zero, alu_overflow, alu_carry_out} =
            alu_f(alu_a, alu_b, alu_cntrl, alu_shiftdir);
    end

    wire [3:0] flag_reg = {flag_n, flag_z, flag_v, flag_c};

`ifdef ALU_SCHED_FLAGREG_EN
    localparam bit FLAGREG = 1'b1;
`else
    localparam bit FLAGREG = 1'b0;
`endif

    typedef struct {
        int          owner;
        logic [63:0] res;
        logic [3:0]  fl;
        logic [3:0]  fr;
        int          cyc;
        bit          seen;
    } exp_t;

    exp_t q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    int   last_g  = 1;
    logic [3:0] model_fr = 4'b0000;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Accept sampler: decides the expected winner from the arbitration rule,
    // computes the expected response and pushes it.
    always begin
        @(negedge clk);
        #2;
        if (reset_n) begin
            if (q.size() != 0) chk("ready_while_busy", {62'd0, req_ready}, 64'd0);
            if ((req_valid & req_ready) != 2'b00) begin
                int          eg;
                logic [67:0] r;
                exp_t        e;
                if (req_valid == 2'b11) eg = (last_g == 1) ? 0 : 1;
                else                    eg = req_valid[1] ? 1 : 0;
                chk("grant", {62'd0, req_ready}, (eg == 1) ? 64'd2 : 64'd1);
                r       = alu_f(req_a[eg], req_b[eg], req_cntrl[eg], req_shiftdir[eg]);
                e.owner = eg;
                e.res   = r[67:4];
                e.fl    = r[3:0];
                if (FLAGREG && req_setflags[eg]) model_fr = r[3:0];
                e.fr    = FLAGREG ? model_fr : 4'b0000;
                e.cyc   = cyc;
                e.seen  = 1'b0;
                q.push_back(e);
                last_g  = eg;
            end
        end
    end

    // Response monitor: compares every presented response with the head of
    // the scoreboard and pops it on the owner's handshake.
    always begin
        @(negedge clk);
        if (reset_n) begin
            if (rsp_valid != 2'b00) begin
                if (q.size() == 0) begin
                    chk("unexpected_rsp_valid", {62'd0, rsp_valid}, 64'd0);
                end else begin
                    chk("rsp_valid_owner", {62'd0, rsp_valid}, (q[0].owner == 1) ? 64'd2 : 64'd1);
                    chk("rsp_result", rsp_result, q[0].res);
                    chk("rsp_flags", {60'd0, rsp_flags}, {60'd0, q[0].fl});
                    chk("flag_reg", {60'd0, flag_reg}, {60'd0, q[0].fr});
                    if (!q[0].seen) begin
                        chk("latency", 64'(cyc - q[0].cyc), 64'd2);
                        q[0].seen = 1'b1;
                    end
                    if (rsp_ready[q[0].owner]) void'(q.pop_front());
                end
            end else if (q.size() != 0 && cyc > q[0].cyc + 2) begin
                fail_now("rsp_missing");
                void'(q.pop_front());
            end
        end
    end

    task automatic set_req(input int r, input logic [63:0] a, input logic [63:0] b,
                           input logic [2:0] op, input logic dir, input logic sf);
        req_valid[r]    = 1'b1;
        req_a[r]        = a;
        req_b[r]        = b;
        req_cntrl[r]    = op;
        req_shiftdir[r] = dir;
        req_setflags[r] = sf;
    endtask

    // Returns the winner and the number of negedges waited; ends just after
    // the accept edge.
    task automatic wait_accept(output int g, output int n);
        g = -1;
        n = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            #2;
            if (reset_n && (req_valid & req_ready) != 2'b00) begin
                g = req_ready[1] ? 1 : 0;
                n = i;
                break;
            end
        end
        if (g < 0) fail_now("accept_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input int r);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rsp_valid[r]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) fail_now("rsp_timeout");
    endtask

    task automatic assert_reset();
        reset_n  = 1'b0;
        q.delete();
        last_g   = 1;
        model_fr = 4'b0000;
    endtask

    task automatic drain();
        req_valid = 2'b00;
        rsp_ready = 2'b11;
        repeat (5) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int g;
        int n;
        int seq_ok;
        logic [3:0] sub_fr;
        sub_fr = FLAGREG ? 4'b0101 : 4'b0000;

        // Reset values, with both requests raised during reset
        reset_n      = 1'b0;
        req_valid    = 2'b11;
        req_a        = '0;
        req_b        = '0;
        req_cntrl    = '0;
        req_shiftdir = 2'b00;
        req_setflags = 2'b00;
        rsp_ready    = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_req_ready", {62'd0, req_ready}, 64'd0);
        chk("reset_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("reset_alu_a", alu_a, 64'd0);
        chk("reset_alu_b", alu_b, 64'd0);
        chk("reset_cntrl_dir", {60'd0, alu_cntrl, alu_shiftdir}, 64'd0);
        chk("reset_rsp", {rsp_result[59:0], rsp_flags}, 64'd0);
        chk("reset_flags", {60'd0, flag_reg}, 64'd0);
        req_valid = 2'b00;
        #2 reset_n = 1'b1;

        // ADD 5 + 7 from requester 0
        rsp_ready = 2'b11;
        @(posedge clk); #1;
        set_req(0, 64'd5, 64'd7, 3'b010, 1'b0, 1'b1);
        wait_accept(g, n);
        req_valid[0] = 1'b0;
        chk("t1_grant", 64'(g), 64'd0);
        wait_rsp(0);
        chk("t1_result", rsp_result, 64'd12);
        chk("t1_rsp_flags", {60'd0, rsp_flags}, 64'd0);
        chk("t1_flag_reg", {60'd0, flag_reg}, 64'd0);
        @(posedge clk); #1;

        // SUB 3 - 3 from requester 1
        set_req(1, 64'd3, 64'd3, 3'b011, 1'b0, 1'b1);
        wait_accept(g, n);
        req_valid[1] = 1'b0;
        chk("t2_grant", 64'(g), 64'd1);
        wait_rsp(1);
        chk("t2_result", rsp_result, 64'd0);
        chk("t2_rsp_flags", {60'd0, rsp_flags}, 64'b0101);
        chk("t2_flag_reg", {60'd0, flag_reg}, {60'd0, sub_fr});
        @(posedge clk); #1;

        // AND all-ones & 0 without setflags: flag register must hold
        set_req(0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 3'b100, 1'b0, 1'b0);
        wait_accept(g, n);
        req_valid[0] = 1'b0;
        wait_rsp(0);
        chk("t5_result", rsp_result, 64'd0);
        chk("t5_rsp_flags", {60'd0, rsp_flags}, 64'b0100);
        chk("t5_flag_reg_hold", {60'd0, flag_reg}, {60'd0, sub_fr});
        @(posedge clk); #1;

        // Fresh reset, then both requesters held valid: grants alternate 0,1,0,1
        assert_reset();
        @(posedge clk); #2 reset_n = 1'b1;
        @(posedge clk); #1;
        set_req(0, 64'd10, 64'd4, 3'b011, 1'b0, 1'b1);
        set_req(1, 64'd6, 64'd9, 3'b010, 1'b0, 1'b0);
        seq_ok = 1;
        for (int i = 0; i < 4; i++) begin
            wait_accept(g, n);
            chk("t3_grant_seq", 64'(g), 64'(i % 2));
            if (g >= 0) req_cntrl[g] = (req_cntrl[g] == 3'b011) ? 3'b110 : 3'b011;
        end
        drain();

        // Held response: rsp_ready[0]=0 (non-owner ready high) while req1 waits
        rsp_ready = 2'b10;
        set_req(0, 64'd100, 64'd23, 3'b010, 1'b0, 1'b0);
        set_req(1, 64'd8, 64'd2, 3'b001, 1'b1, 1'b0);
        wait_accept(g, n);
        chk("t4_first_grant", 64'(g), 64'd0);
        wait_rsp(0);
        for (int i = 0; i < 5; i++) begin
            chk("t4_ready_held", {62'd0, req_ready}, 64'd0);
            chk("t4_valid_held", {62'd0, rsp_valid}, 64'd1);
            chk("t4_result_held", rsp_result, 64'd123);
            @(negedge clk);
        end
        @(posedge clk); #1;
        rsp_ready = 2'b01;
        wait_accept(g, n);
        chk("t4_second_grant", 64'(g), 64'd1);
        chk("t4_second_accept_delay", 64'(n), 64'd2);
        drain();

        // Reset during EXEC: op dropped, flags cleared
        set_req(0, 64'd3, 64'd3, 3'b011, 1'b0, 1'b1);
        wait_accept(g, n);
        req_valid[0] = 1'b0;
        wait_rsp(0);
        @(posedge clk); #1;
        set_req(0, 64'hDEAD_BEEF_0000_0001, 64'h1234, 3'b111, 1'b1, 1'b1);
        wait_accept(g, n);
        req_valid[0] = 1'b0;
        assert_reset();
        #1;
        chk("t6_rsp_valid", {62'd0, rsp_valid}, 64'd0);
        chk("t6_req_ready", {62'd0, req_ready}, 64'd0);
        chk("t6_alu_a", alu_a, 64'd0);
        chk("t6_alu_b", alu_b, 64'd0);
        chk("t6_cntrl_dir", {60'd0, alu_cntrl, alu_shiftdir}, 64'd0);
        chk("t6_rsp", {rsp_result[59:0], rsp_flags}, 64'd0);
        chk("t6_flags", {60'd0, flag_reg}, 64'd0);
        @(posedge clk); @(posedge clk); #2 reset_n = 1'b1;
        begin
            logic [1:0] seen_v;
            seen_v = 2'b00;
            repeat (6) begin
                @(negedge clk);
                seen_v = seen_v | rsp_valid;
            end
            chk("t6_no_dropped_rsp", {62'd0, seen_v}, 64'd0);
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            @(posedge clk); #1;
            req_valid = 2'($urandom);
            for (int r = 0; r < 2; r++) begin
                req_a[r]        = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
                req_b[r]        = ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 20)) : {$urandom, $urandom};
                req_cntrl[r]    = 3'($urandom);
                req_shiftdir[r] = 1'($urandom);
                req_setflags[r] = 1'($urandom);
            end
            rsp_ready = 2'($urandom);
        end
        drain();
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
